tmds_decoder: RTL and testbench

Receive-side TMDS channel decoder for the HDMI path. It takes one raw 10-bit word per pixel clock from a deserializer whose word boundary is arbitrary. It finds the symbol boundary using control-token detection, then decodes each aligned symbol into 8-bit video data or a 2-bit control code. Three instances, one per colour channel, form the front of an HDMI receiver paired with the existing transmitter.

---
 rtl/tmds_pkg.sv | 44 ++++
 rtl/tmds_word_aligner.sv | 127 ++++++++++++
 rtl/tmds_decoder.sv | 64 ++++++
 tb/tb_tmds_decoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS token constants, aligner states and symbol decode helpers
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] r;
        d    = q[9] ? ~q[7:0] : q[7:0];
        r    = '0;
        r[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return r;
    endfunction

    // Returns {is_token, c1, c0}; non-token symbols return all zeros.
    function automatic logic [2:0] tmds_ctrl_code(input logic [9:0] q);
        logic [2:0] c;
        case (q)
            TOKEN_00: c = 3'b100;
            TOKEN_01: c = 3'b101;
            TOKEN_10: c = 3'b110;
            TOKEN_11: c = 3'b111;
            default:  c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic tmds_is_token(input logic [9:0] q);
        return (q == TOKEN_00) || (q == TOKEN_01) || (q == TOKEN_10) || (q == TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - control-token word alignment: window, offset search, lock FSM, stage-1 registers
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_GAP    = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw,
    output logic [9:0] sym,
    output logic       sym_tok,
    output logic [1:0] sym_ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int TW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [TW-1:0] TOK_LAST = TW'(LOCK_COUNT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP - 1);

    align_state_t  state, state_d;
    logic [TW-1:0] tok_cnt, tok_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [3:0]    off_q, off_d, first_off, sel_off;
    logic [9:0]    raw_prev, sel_sym, hit;
    logic [18:0]   win;
    logic [2:0]    sel_code;
    logic          found;

    // Bit 19 of the full window is never part of any candidate, so it is dropped.
    assign win = {raw[8:0], raw_prev};

    always_comb begin
        hit = '0;
        for (int o = 0; o < 10; o++) begin
            hit[o] = tmds_is_token(win[o +: 10]);
        end
    end

    always_comb begin
        first_off = '0;
        for (int o = 9; o >= 0; o--) begin
            if (hit[o]) first_off = 4'(o);
        end
    end

    assign found    = |hit;
    assign sel_off  = (state == SEARCH) ? first_off : off_q;
    assign sel_sym  = win[{1'b0, sel_off} +: 10];
    assign sel_code = tmds_ctrl_code(sel_sym);

    always_comb begin
        state_d = state;
        tok_d   = tok_cnt;
        gap_d   = gap_cnt;
        off_d   = off_q;
        case (state)
            SEARCH: begin
                if (found) begin
                    off_d   = first_off;
                    tok_d   = TW'(1);
                    gap_d   = '0;
                    state_d = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (sel_code[2]) begin
                    tok_d = tok_cnt + TW'(1);
                    if (tok_cnt == TOK_LAST) begin
                        state_d = LOCKED;
                        gap_d   = '0;
                    end
                end else begin
                    state_d = SEARCH;
                    tok_d   = '0;
                end
            end
            LOCKED: begin
                // A token on the expiring cycle still resets the gap.
                if (sel_code[2]) begin
                    gap_d = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_d = SEARCH;
                    gap_d   = '0;
                    tok_d   = '0;
                end else begin
                    gap_d = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_d = SEARCH;
                tok_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_prev <= '0;
            state    <= SEARCH;
            tok_cnt  <= '0;
            gap_cnt  <= '0;
            off_q    <= '0;
            sym      <= '0;
            sym_tok  <= 1'b0;
            sym_ctrl <= '0;
            locked   <= 1'b0;
            offset   <= '0;
        end else begin
            raw_prev <= raw;
            state    <= state_d;
            tok_cnt  <= tok_d;
            gap_cnt  <= gap_d;
            off_q    <= off_d;
            sym      <= sel_sym;
            sym_tok  <= sel_code[2];
            sym_ctrl <= sel_code[1:0];
            // A symbol counts as locked if it completed the lock or was examined while locked.
            locked   <= (state == LOCKED) || (state_d == LOCKED);
            offset   <= ((state != SEARCH) || (state_d != SEARCH)) ? off_d : 4'd0;
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder top: word aligner plus stage-2 symbol decode registers
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_GAP    = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_raw,
    output logic [7:0] o_data,
    output logic       o_de,
    output logic [1:0] o_ctrl,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    logic [9:0] a_sym;
    logic       a_tok;
    logic [1:0] a_ctrl;
    logic       a_locked;
    logic [3:0] a_offset;

    tmds_word_aligner #(
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_GAP    (MAX_GAP)
    ) u_aligner (
        .clk      (clk),
        .rst      (rst),
        .raw      (i_raw),
        .sym      (a_sym),
        .sym_tok  (a_tok),
        .sym_ctrl (a_ctrl),
        .locked   (a_locked),
        .offset   (a_offset)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data   <= '0;
            o_de     <= 1'b0;
            o_ctrl   <= '0;
            o_locked <= 1'b0;
            o_offset <= '0;
        end else begin
            o_locked <= a_locked;
            o_offset <= a_offset;
            if (!a_locked) begin
                o_de   <= 1'b0;
                o_data <= '0;
                o_ctrl <= '0;
            end else if (a_tok) begin
                o_de   <= 1'b0;
                o_data <= '0;
                o_ctrl <= a_ctrl;
            end else begin
                // o_ctrl keeps the last control code through video periods.
                o_de   <= 1'b1;
                o_data <= tmds_decode_data(a_sym);
            end
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed table-driven bench for tmds_decoder at alignment offset 3
module tb_tmds_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] i_raw = '0;
    logic [7:0] o_data;
    logic       o_de;
    logic [1:0] o_ctrl;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_decoder #(.LOCK_COUNT(8), .MAX_GAP(2048)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (i_raw),
        .o_data   (o_data),
        .o_de     (o_de),
        .o_ctrl   (o_ctrl),
        .o_locked (o_locked),
        .o_offset (o_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       locked;
        logic [3:0] offset;
    } vec_t;

    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] DAT = 10'h100;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] hi = '0;
    vec_t       pend[$];
    vec_t       tbl[20];

    function automatic vec_t mk(input logic [9:0] s, input logic de, input logic [7:0] d,
                                input logic [1:0] c, input logic l, input logic [3:0] off);
        vec_t v;
        v.sym = s; v.de = de; v.data = d; v.ctrl = c; v.locked = l; v.offset = off;
        return v;
    endfunction

    task automatic check_rec(input string name, input vec_t e);
        n_checks++;
        if (o_de === e.de && o_data === e.data && o_ctrl === e.ctrl && o_locked === e.locked &&
            (!e.locked || o_offset === e.offset)) begin
            n_pass++;
        end else begin
            $display("FAIL %s sym=%h: got de=%b data=%h ctrl=%b locked=%b offset=%0d, want de=%b data=%h ctrl=%b locked=%b offset=%0d",
                     name, e.sym, o_de, o_data, o_ctrl, o_locked, o_offset,
                     e.de, e.data, e.ctrl, e.locked, e.offset);
        end
    endtask

    // Sends one symbol at offset 3; each output slot is compared three sends later.
    task automatic step(input string name, input vec_t v);
        @(posedge clk);
        #1;
        i_raw = {v.sym[6:0], hi};
        hi    = v.sym[9:7];
        pend.push_back(v);
        @(negedge clk);
        if (pend.size() > 3) check_rec(name, pend.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        hi  = '0;
        pend.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            i_raw = 10'($urandom);
            @(negedge clk);
            check_rec("reset", mk(10'h000, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0));
        end
        i_raw = '0;
        rst   = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[1]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[2]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[3]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[4]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[5]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[6]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b0, 4'd3);
        tbl[7]  = mk(T00,    1'b0, 8'h00, 2'b00, 1'b1, 4'd3);
        tbl[8]  = mk(10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 4'd3);
        tbl[9]  = mk(10'h2FF, 1'b1, 8'hFE, 2'b00, 1'b1, 4'd3);
        tbl[10] = mk(10'h0AB, 1'b0, 8'h00, 2'b01, 1'b1, 4'd3);
        tbl[11] = mk(10'h154, 1'b0, 8'h00, 2'b10, 1'b1, 4'd3);
        tbl[12] = mk(10'h2AB, 1'b0, 8'h00, 2'b11, 1'b1, 4'd3);
        tbl[13] = mk(10'h1FF, 1'b1, 8'h01, 2'b11, 1'b1, 4'd3);
        tbl[14] = mk(10'h0F0, 1'b1, 8'hEE, 2'b11, 1'b1, 4'd3);
        tbl[15] = mk(T00,    1'b0, 8'h00, 2'b00, 1'b1, 4'd3);
        tbl[16] = mk(10'h3C3, 1'b1, 8'h44, 2'b00, 1'b1, 4'd3);
        tbl[17] = mk(T00,    1'b0, 8'h00, 2'b00, 1'b1, 4'd3);
        tbl[18] = mk(T00,    1'b0, 8'h00, 2'b00, 1'b1, 4'd3);
        tbl[19] = mk(T00,    1'b0, 8'h00, 2'b00, 1'b1, 4'd3);

        do_reset();

        for (int i = 0; i < 20; i++) step("table", tbl[i]);

        // Asynchronous reset while locked, between clock edges.
        #1;
        n_checks++;
        if (o_locked === 1'b1) n_pass++;
        else $display("FAIL pre_reset_locked: got %b, want 1", o_locked);
        rst = 1'b0;
        #1;
        check_rec("async_reset", mk(10'h000, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0));
        n_checks++;
        if (o_offset === 4'd0) n_pass++;
        else $display("FAIL async_reset_offset: got %0d, want 0", o_offset);

        do_reset();

        // Verify break: five tokens, one data symbol, then a fresh run of eight tokens.
        for (int i = 0; i < 5; i++) step("verify_break", mk(T00, 1'b0, 8'h00, 2'b00, 1'b0, 4'd3));
        step("verify_break", mk(DAT, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0));
        for (int i = 0; i < 8; i++)
            step("relock", mk(T00, 1'b0, 8'h00, 2'b00, (i == 7), 4'd3));
        for (int i = 0; i < 3; i++) step("relock", mk(T00, 1'b0, 8'h00, 2'b00, 1'b1, 4'd3));

        // Gap: 2047 data symbols then a token stays locked; 2048 data symbols drop lock.
        for (int i = 0; i < 2047; i++) step("gap_hold", mk(DAT, 1'b1, 8'h00, 2'b00, 1'b1, 4'd3));
        step("gap_token", mk(T00, 1'b0, 8'h00, 2'b00, 1'b1, 4'd3));
        for (int i = 0; i < 2048; i++) step("gap_expire", mk(DAT, 1'b1, 8'h00, 2'b00, 1'b1, 4'd3));
        for (int i = 0; i < 6; i++) step("unlocked", mk(DAT, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
